// File: rtl/sdram_inport_arbiter.sv
// sdram_inport_arbiter: two-requester, one-outstanding arbiter for the SDRAM
// controller core port. Grant is registered and round-robin on ties.
// Optional build macro SDRAM_ARB_TIMEOUT_EN adds a WAIT_ACK watchdog and DRAIN state.
module sdram_inport_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W/8-1:0] m0_wr_i,
  input  logic                m0_rd_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_accept_o,
  output logic                m0_ack_o,
  output logic                m0_error_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic [DATA_W/8-1:0] m1_wr_i,
  input  logic                m1_rd_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_accept_o,
  output logic                m1_ack_o,
  output logic                m1_error_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic [DATA_W/8-1:0] out_wr_o,
  output logic                out_rd_o,
  output logic [ADDR_W-1:0]   out_addr_o,
  output logic [DATA_W-1:0]   out_wdata_o,
  input  logic                out_accept_i,
  input  logic                out_ack_i,
  input  logic                out_error_i,
  input  logic [DATA_W-1:0]   out_rdata_i,
  output logic                busy_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W      = 16;
  localparam int unsigned TMO_CYCLES = 4096;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_DRAIN} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK} state_t;
`endif

  state_t r_state, w_state_nxt;
  logic   r_grant, w_grant_nxt;
  logic   r_last_grant, w_last_grant_nxt;
  logic   w_timeout;

  logic              w_pend0, w_pend1;
  logic              w_sel_rd;
  logic [STRB_W-1:0] w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_pend0     = m0_rd_i | (|m0_wr_i);
  assign w_pend1     = m1_rd_i | (|m1_wr_i);
  assign w_sel_rd    = r_grant ? m1_rd_i    : m0_rd_i;
  assign w_sel_wr    = r_grant ? m1_wr_i    : m0_wr_i;
  assign w_sel_addr  = r_grant ? m1_addr_i  : m0_addr_i;
  assign w_sel_wdata = r_grant ? m1_wdata_i : m0_wdata_i;
  assign busy_o      = (r_state != ST_IDLE);

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;

  // Watchdog: counts cycles spent in WAIT_ACK, cleared elsewhere
  always_ff @(posedge clock) begin
    if (reset || r_state != ST_WAIT_ACK) r_tmo_cnt <= '0;
    else                                 r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  assign w_timeout = (r_state == ST_WAIT_ACK) && !out_ack_i &&
                     (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State, grant and round-robin history registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next-state, grant selection and last-grant update
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_pend0 || w_pend1) begin
          w_state_nxt = ST_ISSUE;
          w_grant_nxt = (w_pend0 && w_pend1) ? ~r_last_grant : w_pend1;
        end
      end
      ST_ISSUE: begin
        if (out_accept_i) w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (out_ack_i) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant;
        end else if (w_timeout) begin
`ifdef SDRAM_ARB_TIMEOUT_EN
          w_state_nxt      = ST_DRAIN;
`endif
          w_last_grant_nxt = r_grant;
        end
      end
`ifdef SDRAM_ARB_TIMEOUT_EN
      ST_DRAIN: begin
        // Late core ack is swallowed here
        if (out_ack_i) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output routing: request forward in ISSUE, response return in WAIT_ACK
  always_comb begin
    out_rd_o    = 1'b0;
    out_wr_o    = '0;
    out_addr_o  = '0;
    out_wdata_o = '0;
    m0_accept_o = 1'b0;
    m1_accept_o = 1'b0;
    m0_ack_o    = 1'b0;
    m1_ack_o    = 1'b0;
    m0_error_o  = 1'b0;
    m1_error_o  = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    case (r_state)
      ST_ISSUE: begin
        out_rd_o    = w_sel_rd;
        out_wr_o    = w_sel_rd ? '0 : w_sel_wr;  // rd wins over a conflicting wr
        out_addr_o  = w_sel_addr;
        out_wdata_o = w_sel_wdata;
        m0_accept_o = out_accept_i & ~r_grant;
        m1_accept_o = out_accept_i & r_grant;
      end
      ST_WAIT_ACK: begin
        if (w_timeout) begin
          m0_ack_o   = ~r_grant;
          m1_ack_o   = r_grant;
          m0_error_o = ~r_grant;
          m1_error_o = r_grant;
        end else if (r_grant) begin
          m1_ack_o   = out_ack_i;
          m1_error_o = out_error_i;
          m1_rdata_o = out_rdata_i;
        end else begin
          m0_ack_o   = out_ack_i;
          m0_error_o = out_error_i;
          m0_rdata_o = out_rdata_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_inport_arbiter.sv
// Directed self-checking bench for sdram_inport_arbiter.
// Define SDRAM_ARB_TIMEOUT_EN for both files to include the watchdog scenario.
module tb_sdram_inport_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [STRB_W-1:0] m0_wr, m1_wr;
  logic              m0_rd, m1_rd;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_accept, m0_ack, m0_error;
  logic              m1_accept, m1_ack, m1_error;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [STRB_W-1:0] out_wr;
  logic              out_rd;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_wdata;
  logic              out_accept, out_ack, out_error;
  logic [DATA_W-1:0] out_rdata;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sdram_inport_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .m0_wr_i(m0_wr), .m0_rd_i(m0_rd), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_accept_o(m0_accept), .m0_ack_o(m0_ack), .m0_error_o(m0_error), .m0_rdata_o(m0_rdata),
    .m1_wr_i(m1_wr), .m1_rd_i(m1_rd), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_accept_o(m1_accept), .m1_ack_o(m1_ack), .m1_error_o(m1_error), .m1_rdata_o(m1_rdata),
    .out_wr_o(out_wr), .out_rd_o(out_rd), .out_addr_o(out_addr), .out_wdata_o(out_wdata),
    .out_accept_i(out_accept), .out_ack_i(out_ack), .out_error_i(out_error),
    .out_rdata_i(out_rdata), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (drive point)
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Move to the falling edge of the current cycle (sample point)
  task automatic smp();
    @(negedge clock);
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, ".busy"},  64'(busy), 64'd0);
    chk({tag, ".outs"},  64'({out_rd, out_wr, out_addr, out_wdata}), 64'd0);
    chk({tag, ".m0"},    64'({m0_accept, m0_ack, m0_error, m0_rdata}), 64'd0);
    chk({tag, ".m1"},    64'({m1_accept, m1_ack, m1_error, m1_rdata}), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    m0_wr = '0; m0_rd = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_wr = '0; m1_rd = 1'b0; m1_addr = '0; m1_wdata = '0;
    out_accept = 1'b0; out_ack = 1'b0; out_error = 1'b0; out_rdata = '0;
    cyc(); cyc();
    reset = 1'b0;
    smp();
    chk_all_quiet("reset");

    // m0 read, core accepts after 3 ISSUE cycles, acks with DEADBEEF
    cyc();
    m0_rd = 1'b1; m0_addr = 32'h8000_0010;
    smp();
    chk("t1.idle_rd", 64'(out_rd), 64'd0);
    chk("t1.idle_busy", 64'(busy), 64'd0);
    cyc();
    smp();
    chk("t1.issue_rd", 64'(out_rd), 64'd1);
    chk("t1.issue_addr", 64'(out_addr), 64'h8000_0010);
    chk("t1.no_acc0", 64'(m0_accept), 64'd0);
    cyc(); smp();
    chk("t1.no_acc1", 64'(m0_accept), 64'd0);
    cyc();
    out_accept = 1'b1;
    smp();
    chk("t1.acc", 64'({m0_accept, m1_accept}), 64'b10);
    cyc();
    out_accept = 1'b0; m0_rd = 1'b0; m0_addr = '0;
    smp();
    chk("t1.wait_rd", 64'(out_rd), 64'd0);
    chk("t1.wait_busy", 64'(busy), 64'd1);
    chk("t1.wait_noack", 64'(m0_ack), 64'd0);
    cyc();
    out_ack = 1'b1; out_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t1.ack", 64'(m0_ack), 64'd1);
    chk("t1.rdata", 64'(m0_rdata), 64'hDEAD_BEEF);
    chk("t1.m1_quiet", 64'({m1_accept, m1_ack, m1_error, m1_rdata}), 64'd0);
    cyc();
    out_ack = 1'b0; out_rdata = '0;
    smp();
    chk_all_quiet("t1.idle");

    // Tie from reset: m0 read 0x100 first, then m1 write 0x200
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m0_rd = 1'b1; m0_addr = 32'h100;
    m1_wr = 4'hF; m1_addr = 32'h200; m1_wdata = 32'h1234_5678;
    smp();
    chk("t2.idle_wr", 64'({out_wr, out_wdata}), 64'd0);
    cyc();
    out_accept = 1'b1;
    smp();
    chk("t2.g0_addr", 64'(out_addr), 64'h100);
    chk("t2.g0_rdwr", 64'({out_rd, out_wr}), 64'b1_0000);
    chk("t2.g0_wdata", 64'(out_wdata), 64'd0);
    chk("t2.g0_acc", 64'({m0_accept, m1_accept}), 64'b10);
    cyc();
    out_accept = 1'b0; m0_rd = 1'b0; m0_addr = '0;
    out_ack = 1'b1; out_rdata = 32'hAAAA;
    smp();
    chk("t2.g0_ack", 64'({m0_ack, m1_ack}), 64'b10);
    chk("t2.g0_rdata", 64'(m0_rdata), 64'hAAAA);
    cyc();
    out_ack = 1'b0; out_rdata = '0;
    smp();
    chk("t2.idle2_wr", 64'({out_wr, out_wdata}), 64'd0);
    cyc();
    out_accept = 1'b1;
    smp();
    chk("t2.g1_wr", 64'({out_rd, out_wr}), 64'b0_1111);
    chk("t2.g1_wdata", 64'(out_wdata), 64'h1234_5678);
    chk("t2.g1_addr", 64'(out_addr), 64'h200);
    chk("t2.g1_acc", 64'({m0_accept, m1_accept}), 64'b01);
    cyc();
    out_accept = 1'b0; m1_wr = '0; m1_addr = '0; m1_wdata = '0;
    out_ack = 1'b1;
    smp();
    chk("t2.g1_ack", 64'({m0_ack, m1_ack}), 64'b01);
    chk("t2.g1_wr_off", 64'({out_wr, out_wdata}), 64'd0);
    cyc();
    out_ack = 1'b0;

    // Both continuously pending: alternate m0,m1,... (m1 was served last)
    m0_rd = 1'b1; m0_addr = 32'hA0;
    m1_rd = 1'b1; m1_addr = 32'hB1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      out_accept = 1'b1;
      smp();
      chk($sformatf("t3.acc%0d", i), 64'({m0_accept, m1_accept}),
          (i % 2 == 0) ? 64'b10 : 64'b01);
      chk($sformatf("t3.addr%0d", i), 64'(out_addr),
          (i % 2 == 0) ? 64'hA0 : 64'hB1);
      cyc();
      out_accept = 1'b0; out_ack = 1'b1;
      smp();
      chk($sformatf("t3.ack%0d", i), 64'({m0_ack, m1_ack}),
          (i % 2 == 0) ? 64'b10 : 64'b01);
      cyc();
      out_ack = 1'b0;
    end

    // Conflicting rd+wr treated as read; ack during ISSUE ignored
    m1_rd = 1'b0; m1_addr = '0;
    m0_wr = 4'hF; m0_wdata = 32'h5555_0000;
    cyc();
    out_ack = 1'b1; out_rdata = 32'h77;
    smp();
    chk("t4.rd_wins", 64'({out_rd, out_wr}), 64'b1_0000);
    chk("t4.issue_ack_ignored", 64'({m0_ack, m1_ack, m0_rdata}), 64'd0);
    cyc();
    out_ack = 1'b0; out_rdata = '0;
    smp();
    chk("t4.still_issue", 64'({busy, out_rd}), 64'b11);

    // Reset while in WAIT_ACK abandons the transaction
    cyc();
    out_accept = 1'b1;
    smp();
    chk("t5.acc", 64'(m0_accept), 64'd1);
    cyc();
    out_accept = 1'b0;
    m0_rd = 1'b0; m0_wr = '0; m0_addr = '0; m0_wdata = '0;
    reset = 1'b1;
    smp();
    chk("t5.in_wait", 64'(busy), 64'd1);
    cyc();
    reset = 1'b0;
    smp();
    chk_all_quiet("t5.after_rst");
    cyc();
    m1_wr = 4'h3; m1_addr = 32'h44; m1_wdata = 32'hCAFE;
    smp();
    cyc();
    out_accept = 1'b1;
    smp();
    chk("t5.m1_fwd", 64'({out_wr, out_addr[7:0]}), 64'h344);
    chk("t5.m1_acc", 64'({m0_accept, m1_accept}), 64'b01);
    cyc();
    out_accept = 1'b0; m1_wr = '0; m1_addr = '0; m1_wdata = '0;
    out_ack = 1'b1; out_error = 1'b1; out_rdata = 32'h55;
    smp();
    chk("t5.m1_resp", 64'({m1_ack, m1_error, m1_rdata}), {30'd0, 2'b11, 32'h55});
    chk("t5.m0_quiet", 64'({m0_ack, m0_error}), 64'd0);
    cyc();
    out_ack = 1'b0; out_error = 1'b0; out_rdata = '0;

    // Stray ack while IDLE is not routed and does not move the FSM
    cyc();
    out_ack = 1'b1; out_error = 1'b1; out_rdata = 32'hFFFF;
    smp();
    chk_all_quiet("t6.idle_ack");
    cyc();
    out_ack = 1'b0; out_error = 1'b0; out_rdata = '0;
    smp();
    chk("t6.stay_idle", 64'(busy), 64'd0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    begin
      int n;
      m0_rd = 1'b1; m0_addr = 32'h300;
      cyc();
      out_accept = 1'b1;
      smp();
      chk("t7.acc", 64'(m0_accept), 64'd1);
      n = 0;
      cyc();
      out_accept = 1'b0; m0_rd = 1'b0; m0_addr = '0;
      smp();
      n++;
      while (!m0_ack && n < 5000) begin
        cyc(); smp(); n++;
      end
      chk("t7.tmo_cycles", 64'(n), 64'd4096);
      chk("t7.tmo_resp", 64'({m0_ack, m0_error, m0_rdata}), {30'd0, 2'b11, 32'd0});
      cyc();
      smp();
      chk("t7.drain_busy", 64'(busy), 64'd1);
      cyc();
      out_ack = 1'b1; out_rdata = 32'h99;
      smp();
      chk("t7.late_swallowed", 64'({m0_ack, m1_ack, m0_rdata}), 64'd0);
      cyc();
      out_ack = 1'b0; out_rdata = '0;
      m1_rd = 1'b1; m1_addr = 32'h400;
      smp();
      chk("t7.back_idle", 64'(busy), 64'd0);
      cyc();
      out_accept = 1'b1;
      smp();
      chk("t7.next_acc", 64'({m0_accept, m1_accept}), 64'b01);
      cyc();
      out_accept = 1'b0; m1_rd = 1'b0; m1_addr = '0;
      out_ack = 1'b1;
      smp();
      chk("t7.next_ack", 64'({m1_ack, m1_error}), 64'b10);
      cyc();
      out_ack = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
